// File: rtl/demux_stream_router_pkg.sv
// Shared definitions for the stream router slice.
// - clog2_min1 : ceiling log2, never less than 1, used for select and pointer widths
// - PTR_W/LVL_W: pointer and occupancy widths for the default FIFO depth.
//                Modules that take DEPTH as a parameter derive their own copies
//                through clog2_min1.
package demux_stream_router_pkg;

    localparam int DEF_DEPTH = 4;
    localparam int PTR_W     = $clog2(DEF_DEPTH);
    localparam int LVL_W     = PTR_W + 1;

    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/demux_stream_router_chan.sv
// chan_fifo: single-channel FIFO with DEPTH entries and an explicit occupancy counter.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push, wdata         write strobe and data (caller guarantees !full)
//   pop                 read strobe (caller guarantees valid)
//   rdata, valid        head-of-FIFO data and non-empty flag, from registered state
//   full, level         full flag and occupancy (0..DEPTH)
module chan_fifo
    import demux_stream_router_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [WIDTH-1:0]              wdata,
    input  logic                          pop,
    output logic [WIDTH-1:0]              rdata,
    output logic                          valid,
    output logic                          full,
    output logic [clog2_min1(DEPTH):0]    level
);

    localparam int FPTR_W = clog2_min1(DEPTH);
    localparam int FLVL_W = FPTR_W + 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [FPTR_W-1:0] wr_ptr_reg;
    logic [FPTR_W-1:0] rd_ptr_reg;
    logic [FLVL_W-1:0] level_reg;

    // Storage carries no reset: a stale entry is never visible because
    // valid is derived from the cleared occupancy counter.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= wdata;
    end

    // DEPTH is a power of two, so the pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign rdata = mem[rd_ptr_reg];
    assign valid = (level_reg != '0);
    assign full  = (level_reg == FLVL_W'(DEPTH));
    assign level = level_reg;

    a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && !valid));
    a_level_range:  assert property (@(posedge clk) disable iff (!rst_n) level_reg <= FLVL_W'(DEPTH));

endmodule

// File: rtl/demux_stream_router.sv
// demux_stream_router: routes one valid/ready stream to N_CH output channels,
// each buffered by its own FIFO so a stalled consumer only blocks its own channel.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_data/in_sel        input beat and destination channel
//   in_valid/in_ready     input handshake (in_ready depends on registered state and in_sel only)
//   out_data              channel c at [c*WIDTH +: WIDTH], zero when out_valid[c]=0
//   out_valid/out_ready   per-channel output handshake
//   level                 per-channel occupancy, LVL bits each
//   err_sel/err_clr       sticky out-of-range select flag and its synchronous clear
module demux_stream_router
    import demux_stream_router_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_CH  = 4,
    parameter int DEPTH = 4,
    parameter int SEL_W = clog2_min1(N_CH)
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [WIDTH-1:0]                         in_data,
    input  logic [SEL_W-1:0]                         in_sel,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    output logic [N_CH*WIDTH-1:0]                    out_data,
    output logic [N_CH-1:0]                          out_valid,
    input  logic [N_CH-1:0]                          out_ready,
    output logic [N_CH*(clog2_min1(DEPTH)+1)-1:0]    level,
    output logic                                     err_sel,
    input  logic                                     err_clr
);

    localparam int LVL = clog2_min1(DEPTH) + 1;

    logic              sel_ok;
    logic [N_CH-1:0]   full;
    logic [N_CH-1:0]   push;
    logic [N_CH-1:0]   pop;
    logic              err_sel_reg;

    assign sel_ok = ({1'b0, in_sel} < (SEL_W+1)'(N_CH));

    // Out-of-range selects are always accepted (and dropped) so a bad
    // producer cannot wedge the input.
    always_comb begin
        in_ready = 1'b1;
        for (int c = 0; c < N_CH; c++) begin
            if (in_sel == SEL_W'(c)) in_ready = !full[c];
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
            logic [WIDTH-1:0] rdata;
            logic             valid;

            assign push[gi] = in_valid && sel_ok && (in_sel == SEL_W'(gi)) && !full[gi];
            assign pop[gi]  = valid && out_ready[gi];

            chan_fifo #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk   (clk),
                .rst_n (rst_n),
                .push  (push[gi]),
                .wdata (in_data),
                .pop   (pop[gi]),
                .rdata (rdata),
                .valid (valid),
                .full  (full[gi]),
                .level (level[gi*LVL +: LVL])
            );

            assign out_valid[gi]               = valid;
            assign out_data[gi*WIDTH +: WIDTH] = valid ? rdata : '0;
        end
    endgenerate

    // Setting beats clearing: an error arriving with err_clr must not be lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sel_reg <= 1'b0;
        end else if (in_valid && !sel_ok) begin
            err_sel_reg <= 1'b1;
        end else if (err_clr) begin
            err_sel_reg <= 1'b0;
        end
    end

    assign err_sel = err_sel_reg;

endmodule

// File: tb/tb_demux_stream_router.sv
module tb_demux_stream_router;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Main DUT: WIDTH=8, N_CH=4, DEPTH=4 (level: 4 x 3 bits)
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [11:0] level;
    logic        err_sel;
    logic        err_clr;

    // Second DUT: N_CH=3 so that in_sel=3 is out of range
    logic [7:0]  d3_in_data;
    logic [1:0]  d3_in_sel;
    logic        d3_in_valid;
    logic        d3_in_ready;
    logic [23:0] d3_out_data;
    logic [2:0]  d3_out_valid;
    logic [2:0]  d3_out_ready;
    logic [8:0]  d3_level;
    logic        d3_err_sel;
    logic        d3_err_clr;

    demux_stream_router #(.WIDTH(8), .N_CH(4), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .level(level),
        .err_sel(err_sel), .err_clr(err_clr)
    );

    demux_stream_router #(.WIDTH(8), .N_CH(3), .DEPTH(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(d3_in_data), .in_sel(d3_in_sel),
        .in_valid(d3_in_valid), .in_ready(d3_in_ready), .out_data(d3_out_data),
        .out_valid(d3_out_valid), .out_ready(d3_out_ready), .level(d3_level),
        .err_sel(d3_err_sel), .err_clr(d3_err_clr)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic [7:0]  d;
        logic [3:0]  ordy;
        logic        rdy;     // expected in_ready before the edge
        logic [3:0]  ov;      // expected out_valid after the edge
        logic [31:0] od;      // expected out_data after the edge
        logic [11:0] lv;      // expected level after the edge
    } vec_t;

    vec_t tbl [16];

    task automatic run_vec(input vec_t t, input int idx);
        @(negedge clk);
        in_valid  = t.v;
        in_sel    = t.sel;
        in_data   = t.d;
        out_ready = t.ordy;
        #1;
        check($sformatf("v%0d in_ready", idx), 64'(in_ready), 64'(t.rdy));
        @(posedge clk);
        #1;
        check($sformatf("v%0d out_valid", idx), 64'(out_valid), 64'(t.ov));
        check($sformatf("v%0d out_data", idx), 64'(out_data), 64'(t.od));
        check($sformatf("v%0d level", idx), 64'(level), 64'(t.lv));
        $display("vec %0d: v=%0b sel=%0d d=%02h ordy=%b -> rdy=%0b ov=%b od=%08h lv=%03h",
                 idx, t.v, t.sel, t.d, t.ordy, in_ready, out_valid, out_data, level);
    endtask

    task automatic idle_all();
        in_valid = 0; in_sel = 0; in_data = 0; out_ready = 4'hF; err_clr = 0;
        d3_in_valid = 0; d3_in_sel = 0; d3_in_data = 0; d3_out_ready = 3'h7; d3_err_clr = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " out_valid"}, 64'(out_valid), 64'd0);
        check({tag, " out_data"},  64'(out_data),  64'd0);
        check({tag, " level"},     64'(level),     64'd0);
        check({tag, " err_sel"},   64'(err_sel),   64'd0);
        check({tag, " d3_err_sel"}, 64'(d3_err_sel), 64'd0);
        check({tag, " d3_level"},  64'(d3_level),  64'd0);
    endtask

    logic [7:0] q [$];

    initial begin
        idle_all();
        rst_n = 0;

        // ---------------- reset with random inputs ----------------
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom); in_sel = 2'($urandom); in_data = 8'($urandom);
            out_ready = 4'($urandom); err_clr = 1'($urandom);
            d3_in_valid = 1; d3_in_sel = 2'd3; d3_in_data = 8'($urandom);
            @(posedge clk); #1;
            check_zero("reset");
            $display("reset cycle %0d: ov=%b od=%08h lv=%03h err=%0b", i, out_valid, out_data, level, err_sel);
        end
        @(negedge clk);
        idle_all();
        rst_n = 1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_zero("idle");
        end
        $display("idle 10 cycles after release: ov=%b lv=%03h", out_valid, level);

        // ---------------- basic routing + backpressure tables ----------------
        tbl[0]  = '{1, 0, 8'h11, 4'hF, 1, 4'b0001, 32'h0000_0011, 12'h001};
        tbl[1]  = '{1, 1, 8'h22, 4'hF, 1, 4'b0010, 32'h0000_2200, 12'h008};
        tbl[2]  = '{1, 2, 8'h33, 4'hF, 1, 4'b0100, 32'h0033_0000, 12'h040};
        tbl[3]  = '{1, 3, 8'h44, 4'hF, 1, 4'b1000, 32'h4400_0000, 12'h200};
        tbl[4]  = '{0, 0, 8'h00, 4'hF, 1, 4'b0000, 32'h0000_0000, 12'h000};
        // ch1 stalled: four accepts then full
        tbl[5]  = '{1, 1, 8'hA0, 4'hD, 1, 4'b0010, 32'h0000_A000, 12'h008};
        tbl[6]  = '{1, 1, 8'hA1, 4'hD, 1, 4'b0010, 32'h0000_A000, 12'h010};
        tbl[7]  = '{1, 1, 8'hA2, 4'hD, 1, 4'b0010, 32'h0000_A000, 12'h018};
        tbl[8]  = '{1, 1, 8'hA3, 4'hD, 1, 4'b0010, 32'h0000_A000, 12'h020};
        tbl[9]  = '{1, 1, 8'hA4, 4'hD, 0, 4'b0010, 32'h0000_A000, 12'h020};
        // other channel still flows
        tbl[10] = '{1, 2, 8'hB2, 4'hD, 1, 4'b0110, 32'h00B2_A000, 12'h060};
        // full ch1 with out_ready[1]=1: in_ready must stay low, beat C1 dropped
        tbl[11] = '{1, 1, 8'hC1, 4'hF, 0, 4'b0010, 32'h0000_A100, 12'h018};
        tbl[12] = '{0, 0, 8'h00, 4'hF, 1, 4'b0010, 32'h0000_A200, 12'h010};
        tbl[13] = '{0, 0, 8'h00, 4'hF, 1, 4'b0010, 32'h0000_A300, 12'h008};
        tbl[14] = '{0, 0, 8'h00, 4'hF, 1, 4'b0000, 32'h0000_0000, 12'h000};
        tbl[15] = '{0, 0, 8'h00, 4'hF, 1, 4'b0000, 32'h0000_0000, 12'h000};
        for (int i = 0; i < 16; i++) run_vec(tbl[i], i);

        // ---------------- simultaneous push/pop with pointer wrap ----------------
        q.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1; in_sel = 0; in_data = 8'(8'h01 + i); out_ready = 4'hE;
            q.push_back(in_data);
        end
        @(posedge clk); #1;
        check("wrap prefill level", 64'(level), 64'd2);
        check("wrap prefill head", 64'(out_data), 64'(q[0]));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1; in_sel = 0; in_data = 8'(8'h40 + i); out_ready = 4'hF;
            #1;
            check($sformatf("wrap%0d in_ready", i), 64'(in_ready), 64'd0 + (q.size() < 4));
            q.push_back(in_data);
            void'(q.pop_front());
            @(posedge clk); #1;
            check($sformatf("wrap%0d level", i), 64'(level), 64'd2);
            check($sformatf("wrap%0d head", i), 64'(out_data), 64'(q[0]));
            $display("wrap %0d: push %02h head %02h level %0d", i, 8'(8'h40 + i), out_data[7:0], level[2:0]);
        end
        @(negedge clk);
        in_valid = 0;
        while (q.size() > 0) begin
            void'(q.pop_front());
            @(posedge clk); #1;
            if (q.size() > 0) check("drain head", 64'(out_data), 64'(q[0]));
            else              check("drain empty", 64'(out_valid), 64'd0);
        end

        // ---------------- invalid select on N_CH=3 instance ----------------
        @(negedge clk);
        d3_in_valid = 1; d3_in_sel = 2'd3; d3_in_data = 8'h5A;
        #1;
        check("bad sel in_ready", 64'(d3_in_ready), 64'd1);
        check("bad sel err before edge", 64'(d3_err_sel), 64'd0);
        @(posedge clk); #1;
        check("bad sel err_sel", 64'(d3_err_sel), 64'd1);
        check("bad sel level", 64'(d3_level), 64'd0);
        check("bad sel out_valid", 64'(d3_out_valid), 64'd0);
        $display("bad sel: rdy=%0b err=%0b lv=%03h", d3_in_ready, d3_err_sel, d3_level);
        @(negedge clk);
        d3_in_valid = 0;
        @(posedge clk); #1;
        check("err sticky", 64'(d3_err_sel), 64'd1);
        @(negedge clk);
        d3_err_clr = 1;
        @(posedge clk); #1;
        check("err cleared", 64'(d3_err_sel), 64'd0);
        $display("err_clr alone: err=%0b", d3_err_sel);
        @(negedge clk);
        d3_in_valid = 1; d3_in_sel = 2'd3; d3_err_clr = 1;
        @(posedge clk); #1;
        check("err set beats clr", 64'(d3_err_sel), 64'd1);
        $display("err_clr with bad beat: err=%0b", d3_err_sel);
        @(negedge clk);
        d3_in_valid = 1; d3_in_sel = 2'd2; d3_in_data = 8'h6C; d3_err_clr = 0;
        @(posedge clk); #1;
        check("d3 ch2 valid", 64'(d3_out_valid), 64'b100);
        check("d3 ch2 data", 64'(d3_out_data), 64'h6C_0000);
        check("main err_sel untouched", 64'(err_sel), 64'd0);
        @(negedge clk);
        d3_in_valid = 0;

        // ---------------- asynchronous reset mid-stream ----------------
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1; in_sel = 2; in_data = 8'(8'h70 + i); out_ready = 4'hB;
        end
        @(posedge clk); #1;
        check("pre-reset level ch2", 64'(level), 64'(12'd3 << 6));
        @(negedge clk);
        in_valid = 1; in_sel = 2; in_data = 8'h7F;
        #2;
        rst_n = 0;
        #1;
        check("async rst out_valid", 64'(out_valid), 64'd0);
        check("async rst out_data", 64'(out_data), 64'd0);
        check("async rst level", 64'(level), 64'd0);
        $display("async reset: ov=%b od=%08h lv=%03h", out_valid, out_data, level);
        @(negedge clk);
        idle_all();
        rst_n = 1;
        @(posedge clk); #1;
        check("post-reset empty", 64'(level), 64'd0);
        @(negedge clk);
        in_valid = 1; in_sel = 2; in_data = 8'h77; out_ready = 4'hF;
        #1;
        check("post-reset in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        check("post-reset ov", 64'(out_valid), 64'b0100);
        check("post-reset data", 64'(out_data), 64'h0077_0000);
        $display("post-reset beat: ov=%b od=%08h", out_valid, out_data);
        @(negedge clk);
        in_valid = 0;
        @(posedge clk); #1;
        check("post-reset drained", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
